// File: rtl/sc_pkg.sv
// Shared types and default constants for the stochastic-computing NAND job sequencer.
package sc_pkg;

    localparam int SEQ_W   = 32;
    localparam int NUM_W   = 6;
    localparam int M_W     = 36;
    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 255;

    // Six 6-bit direction numbers, most significant at [35:30].
    localparam logic [M_W-1:0] M1_INIT = {6'd11, 6'd9, 6'd7, 6'd5, 6'd3, 6'd1};
    localparam logic [M_W-1:0] M2_INIT = {6'd1, 6'd11, 6'd9, 6'd7, 6'd5, 6'd3};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLR,
        GEN,
        COMB,
        OUT
    } state_t;

    typedef struct packed {
        logic [M_W-1:0] m1;
        logic [M_W-1:0] m2;
    } m_pair_t;

    function automatic m_pair_t select_m(input logic swap,
                                         input logic [M_W-1:0] m_a,
                                         input logic [M_W-1:0] m_b);
        m_pair_t p;
        p.m1 = swap ? m_b : m_a;
        p.m2 = swap ? m_a : m_b;
        return p;
    endfunction

endpackage

// File: rtl/sc_popcount32.sv
// Combinational popcount of a 32-bit stochastic stream, built as a balanced adder tree.
module sc_popcount32
    import sc_pkg::*;
(
    input  logic [SEQ_W-1:0] data,
    output logic [CNT_W-1:0] count
);

    logic [1:0] lvl1 [16];
    logic [2:0] lvl2 [8];
    logic [3:0] lvl3 [4];
    logic [4:0] lvl4 [2];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            lvl1[i] = {1'b0, data[2*i]} + {1'b0, data[2*i+1]};
        end
        for (int i = 0; i < 8; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
        end
        count = {1'b0, lvl4[0]} + {1'b0, lvl4[1]};
    end

endmodule

// File: rtl/sc_nand_sched.sv
// Job sequencer owning two Sobol SC generators and the NAND combiner: load, clear,
// generate, combine, then hand back the result stream and its popcount.
module sc_nand_sched #(
    parameter int                     SEQ_W   = sc_pkg::SEQ_W,
    parameter int                     NUM_W   = sc_pkg::NUM_W,
    parameter logic [sc_pkg::M_W-1:0] M1_INIT = sc_pkg::M1_INIT,
    parameter logic [sc_pkg::M_W-1:0] M2_INIT = sc_pkg::M2_INIT,
    parameter int                     TIMEOUT = sc_pkg::TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [NUM_W-1:0]           req_a,
    input  logic [NUM_W-1:0]           req_b,
    input  logic                       req_swap,
    output logic                       sc_clr_n,
    output logic                       sc_en,
    output logic [NUM_W-1:0]           sc_num1,
    output logic [NUM_W-1:0]           sc_num2,
    output logic [sc_pkg::M_W-1:0]     sc_m1,
    output logic [sc_pkg::M_W-1:0]     sc_m2,
    input  logic                       sc_done1,
    input  logic                       sc_done2,
    output logic                       nand_en,
    input  logic [SEQ_W-1:0]           nand_out,
    input  logic                       nand_done,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [SEQ_W-1:0]           res_seq,
    output logic [sc_pkg::CNT_W-1:0]   res_count,
    output logic                       res_err,
    output logic                       busy
);
    import sc_pkg::*;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    wait_cnt;
    logic             wait_hit;
    logic             got1;
    logic             got2;
    logic             accept;
    logic             capture;
    logic             abort;
    m_pair_t          m_sel;
    logic [CNT_W-1:0] pop;

    sc_popcount32 u_popcount (
        .data  (nand_out),
        .count (pop)
    );

    assign m_sel    = select_m(req_swap, M1_INIT, M2_INIT);
    assign wait_hit = (wait_cnt == WAIT_MAX);

    // NOTE: every output of this block gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = CLR;
            CLR:  state_nxt = GEN;
            GEN: begin
                // Exit uses the registered sticky flags, giving one cycle between the
                // last done being sampled and nand_en rising.
                if (got1 && got2) begin
                    state_nxt = COMB;
                end else if (wait_hit) begin
                    abort     = 1'b1;
                    state_nxt = OUT;
                end
            end
            COMB: begin
                if (nand_done) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end else if (wait_hit) begin
                    abort     = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (res_valid && res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            sc_clr_n  <= 1'b1;
            sc_en     <= 1'b0;
            nand_en   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            sc_clr_n  <= (state_nxt != CLR);
            sc_en     <= (state_nxt == GEN) || (state_nxt == COMB);
            nand_en   <= (state_nxt == COMB);
            res_valid <= (state_nxt == OUT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_num1   <= '0;
            sc_num2   <= '0;
            sc_m1     <= M1_INIT;
            sc_m2     <= M2_INIT;
            res_seq   <= '0;
            res_count <= '0;
            res_err   <= 1'b0;
        end else begin
            if (accept) begin
                sc_num1 <= req_a;
                sc_num2 <= req_b;
                sc_m1   <= m_sel.m1;
                sc_m2   <= m_sel.m2;
                res_err <= 1'b0;
            end
            if (capture) begin
                res_seq   <= nand_out;
                res_count <= pop;
            end
            if (abort) begin
                res_err   <= 1'b1;
                res_seq   <= '0;
                res_count <= '0;
            end
        end
    end

    // The wait counter restarts whenever GEN or COMB is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else if (state == GEN || state == COMB) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Done flags clear in CLR so a stale pulse from an earlier job cannot count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            got1 <= 1'b0;
            got2 <= 1'b0;
        end else if (state == CLR) begin
            got1 <= 1'b0;
            got2 <= 1'b0;
        end else if (state == GEN) begin
            got1 <= got1 | sc_done1;
            got2 <= got2 | sc_done2;
        end
    end

endmodule

// File: tb/tb_sc_nand_sched.sv
// Self-checking bench for sc_nand_sched: table-driven and random jobs against a
// cycle-budget model, plus reset and mid-job reset sequences.
module tb_sc_nand_sched;

    localparam int          TO = 20;
    localparam logic [35:0] M1 = {6'd11, 6'd9, 6'd7, 6'd5, 6'd3, 6'd1};
    localparam logic [35:0] M2 = {6'd1, 6'd11, 6'd9, 6'd7, 6'd5, 6'd3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_a = '0;
    logic [5:0]  req_b = '0;
    logic        req_swap = 1'b0;
    logic        sc_clr_n;
    logic        sc_en;
    logic [5:0]  sc_num1;
    logic [5:0]  sc_num2;
    logic [35:0] sc_m1;
    logic [35:0] sc_m2;
    logic        sc_done1 = 1'b0;
    logic        sc_done2 = 1'b0;
    logic        nand_en;
    logic [31:0] nand_out = '0;
    logic        nand_done = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_seq;
    logic [5:0]  res_count;
    logic        res_err;
    logic        busy;

    sc_nand_sched #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_swap  (req_swap),
        .sc_clr_n  (sc_clr_n),
        .sc_en     (sc_en),
        .sc_num1   (sc_num1),
        .sc_num2   (sc_num2),
        .sc_m1     (sc_m1),
        .sc_m2     (sc_m2),
        .sc_done1  (sc_done1),
        .sc_done2  (sc_done2),
        .nand_en   (nand_en),
        .nand_out  (nand_out),
        .nand_done (nand_done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_seq   (res_seq),
        .res_count (res_count),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // k1/k2: GEN cycle (0 = first) in which each done pulses, -1 = never.
    // nl: cycles after nand_en rises until nand_done, -1 = never.
    // exp_ne / exp_lat: cycles after the accept edge until nand_en / res_valid.
    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic        swap;
        logic        stale;
        int          k1;
        int          k2;
        int          nl;
        logic [31:0] nval;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_seq;
        logic [5:0]  exp_cnt;
        int          exp_ne;
        int          exp_lat;
    } job_t;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: LOAD and CLR take one cycle each; GEN lasts until one cycle
    // after the later done is sampled, COMB until nand_done is sampled; either phase
    // is cut at TO cycles and the job ends in error with a zero result.
    function automatic job_t model(input job_t j);
        job_t r;
        int   last;
        int   gen_len;
        int   comb_len;
        logic ab;
        r  = j;
        ab = 1'b0;
        if (j.k1 < 0 || j.k2 < 0) last = TO;
        else last = (j.k1 > j.k2) ? j.k1 : j.k2;
        gen_len = last + 2;
        if (gen_len > TO) begin
            gen_len = TO;
            ab      = 1'b1;
        end
        comb_len = 0;
        r.exp_ne = -1;
        if (!ab) begin
            r.exp_ne = 2 + gen_len;
            comb_len = (j.nl < 0) ? TO + 1 : j.nl + 1;
            if (comb_len > TO) begin
                comb_len = TO;
                ab       = 1'b1;
            end
        end
        r.exp_lat = 2 + gen_len + comb_len;
        r.exp_err = ab;
        r.exp_seq = ab ? 32'h0 : j.nval;
        r.exp_cnt = 6'($countones(r.exp_seq));
        return r;
    endfunction

    task automatic run_job(input job_t j, input string tag);
        int          t;
        int          t_en;
        int          t_ne;
        int          clr_lows;
        int          clr_at;
        logic        num_moved;
        logic        ready_seen;
        logic        seen_valid;
        logic        unstable;
        logic        nd_real;
        logic [31:0] seq_hold;
        logic [5:0]  cnt_hold;
        logic [35:0] em1;
        logic [35:0] em2;
        em1 = j.swap ? M2 : M1;
        em2 = j.swap ? M1 : M2;

        @(negedge clk);
        req_a     = j.a;
        req_b     = j.b;
        req_swap  = j.swap;
        req_valid = 1'b1;
        @(negedge clk);
        check({tag, ".accept_ctrl"}, 64'({busy, req_ready, res_valid, res_err}), 64'(4'b1000));
        check({tag, ".num"}, 64'({sc_num1, sc_num2}), 64'({j.a, j.b}));
        check({tag, ".m_sets"}, 64'(sc_m1 ^ {sc_m2[17:0], sc_m2[35:18]}),
              64'(em1 ^ {em2[17:0], em2[35:18]}));
        check({tag, ".m2"}, 64'(sc_m2), 64'(em2));

        t = 0; t_en = -1; t_ne = -1; clr_lows = 0; clr_at = -1;
        num_moved = 1'b0; ready_seen = 1'b0; seen_valid = 1'b0;
        while (t <= 60) begin
            if (!sc_clr_n) begin
                clr_lows++;
                clr_at = t;
            end
            if (t_en < 0 && sc_en) t_en = t;
            if (t_ne < 0 && nand_en) t_ne = t;
            if (res_valid) begin
                seen_valid = 1'b1;
                break;
            end
            if ({sc_num1, sc_num2} !== {j.a, j.b}) num_moved = 1'b1;
            if (req_ready) ready_seen = 1'b1;
            sc_done1  = (j.stale && t <= 1) || (t_en >= 0 && j.k1 >= 0 && t == t_en + j.k1);
            sc_done2  = (j.stale && t <= 1) || (t_en >= 0 && j.k2 >= 0 && t == t_en + j.k2);
            nd_real   = (t_ne >= 0 && j.nl >= 0 && t == t_ne + j.nl);
            nand_done = nd_real || (j.stale && t <= 1);
            nand_out  = nd_real ? j.nval : $urandom();
            req_a     = 6'($urandom());
            req_b     = 6'($urandom());
            req_swap  = ~j.swap;
            @(negedge clk);
            t++;
        end
        sc_done1  = 1'b0;
        sc_done2  = 1'b0;
        nand_done = 1'b0;
        nand_out  = $urandom();

        check({tag, ".res_valid_seen"}, 64'(seen_valid), 64'(1'b1));
        check({tag, ".latency"}, 64'(t), 64'(j.exp_lat));
        check({tag, ".sc_en_rise"}, 64'(t_en), 64'(2));
        check({tag, ".nand_en_rise"}, 64'(t_ne), 64'(j.exp_ne));
        check({tag, ".clr_pulse"}, 64'(clr_lows * 100 + clr_at), 64'(101));
        check({tag, ".num_stable"}, 64'(num_moved), 64'(1'b0));
        check({tag, ".ready_low"}, 64'(ready_seen), 64'(1'b0));
        check({tag, ".result"}, 64'({res_err, res_seq, res_count}),
              64'({j.exp_err, j.exp_seq, j.exp_cnt}));
        check({tag, ".out_ctrl"}, 64'({sc_en, nand_en, busy, req_ready}), 64'(4'b0010));
        check({tag, ".m_held"}, 64'(sc_m1), 64'(em1));

        seq_hold = res_seq;
        cnt_hold = res_count;
        unstable = 1'b0;
        for (int h = 0; h < j.hold; h++) begin
            res_ready = 1'b0;
            req_valid = 1'b1;
            @(negedge clk);
            if (!res_valid || res_seq !== seq_hold || res_count !== cnt_hold ||
                req_ready || res_err !== j.exp_err) unstable = 1'b1;
        end
        if (j.hold > 0) check({tag, ".hold_stable"}, 64'(unstable), 64'(1'b0));

        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = 1'b0;
        check({tag, ".handshake"}, 64'({res_valid, req_ready, busy, res_err}),
              64'({1'b0, 1'b1, 1'b0, j.exp_err}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        job_t tbl [12];
        job_t j;
        logic bad;

        //          a      b      swp   stl   k1  k2  nl  nval          hold err   seq           cnt    ne  lat
        tbl[0]  = '{6'd19, 6'd51, 1'b0, 1'b0,  3,  3,  2, 32'h0000_FFFF,  0, 1'b0, 32'h0000_FFFF, 6'd16,  7, 10};
        tbl[1]  = '{6'd5,  6'd60, 1'b0, 1'b1,  1,  6,  0, 32'h8000_0001,  1, 1'b0, 32'h8000_0001, 6'd2,  10, 11};
        tbl[2]  = '{6'd63, 6'd63, 1'b0, 1'b0,  0,  0,  0, 32'hFFFF_FFFF, 10, 1'b0, 32'hFFFF_FFFF, 6'd32,  4,  5};
        tbl[3]  = '{6'd0,  6'd0,  1'b0, 1'b0,  0,  0,  0, 32'h0000_0000,  0, 1'b0, 32'h0000_0000, 6'd0,   4,  5};
        tbl[4]  = '{6'd10, 6'd20, 1'b1, 1'b0,  0,  0,  1, 32'h1234_5678,  0, 1'b0, 32'h1234_5678, 6'd13,  4,  6};
        tbl[5]  = '{6'd33, 6'd1,  1'b0, 1'b0,  2,  0,  0, 32'hFFFF_0000,  0, 1'b0, 32'hFFFF_0000, 6'd16,  6,  7};
        tbl[6]  = '{6'd7,  6'd9,  1'b0, 1'b0,  0, -1,  0, 32'hDEAD_BEEF,  2, 1'b1, 32'h0000_0000, 6'd0,  -1, 22};
        tbl[7]  = '{6'd12, 6'd34, 1'b0, 1'b0,  1,  1,  0, 32'h0F0F_0F0F,  0, 1'b0, 32'h0F0F_0F0F, 6'd16,  5,  6};
        tbl[8]  = '{6'd2,  6'd3,  1'b0, 1'b0, 18,  0,  0, 32'h0000_00FF,  0, 1'b0, 32'h0000_00FF, 6'd8,  22, 23};
        tbl[9]  = '{6'd4,  6'd5,  1'b1, 1'b0, 19,  3,  0, 32'h0000_CAFE,  0, 1'b1, 32'h0000_0000, 6'd0,  -1, 22};
        tbl[10] = '{6'd6,  6'd7,  1'b0, 1'b0,  0,  0, -1, 32'h0000_ABCD,  0, 1'b1, 32'h0000_0000, 6'd0,   4, 24};
        tbl[11] = '{6'd8,  6'd9,  1'b0, 1'b0,  0,  0, 19, 32'h0000_0007,  0, 1'b0, 32'h0000_0007, 6'd3,   4, 24};

        #2 rst = 1'b0;
        #1;
        check("rst.ctrl", 64'({req_ready, sc_clr_n, sc_en, nand_en, res_valid, res_err, busy}),
              64'(7'b1100000));
        check("rst.num", 64'({sc_num1, sc_num2}), 64'(0));
        check("rst.m1", 64'(sc_m1), 64'(M1));
        check("rst.m2", 64'(sc_m2), 64'(M2));
        check("rst.res", 64'({res_seq, res_count}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle.ctrl", 64'({req_ready, sc_clr_n, sc_en, busy}), 64'(4'b1100));

        for (int i = 0; i < 12; i++) begin
            run_job(tbl[i], $sformatf("vec%0d", i));
        end

        for (int r = 0; r < 10; r++) begin
            j.a     = 6'($urandom());
            j.b     = 6'($urandom());
            j.swap  = 1'($urandom());
            j.stale = 1'($urandom());
            j.k1    = ($urandom_range(0, 9) == 0) ? 19 : int'($urandom_range(0, 6));
            j.k2    = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
            j.nl    = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            j.nval  = $urandom();
            j.hold  = int'($urandom_range(0, 3));
            j       = model(j);
            run_job(j, $sformatf("rnd%0d", r));
        end

        // Reset while the NAND stage is waiting; a late nand_done must not produce a result.
        @(negedge clk);
        req_a     = 6'd3;
        req_b     = 6'd4;
        req_swap  = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 12 && !nand_en; c++) begin
            sc_done1 = sc_en;
            sc_done2 = sc_en;
            @(negedge clk);
        end
        sc_done1 = 1'b0;
        sc_done2 = 1'b0;
        check("mid.in_comb", 64'({nand_en, busy}), 64'(2'b11));
        #2 rst = 1'b0;
        #1;
        check("mid.async_reset", 64'({nand_en, sc_en, busy, res_valid, req_ready, sc_clr_n}),
              64'(6'b000011));
        @(negedge clk);
        rst       = 1'b1;
        nand_done = 1'b1;
        nand_out  = 32'hFFFF_FFFF;
        sc_done1  = 1'b1;
        sc_done2  = 1'b1;
        bad       = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (res_valid || busy || nand_en || sc_en || res_seq !== 32'h0) bad = 1'b1;
        end
        nand_done = 1'b0;
        sc_done1  = 1'b0;
        sc_done2  = 1'b0;
        check("mid.no_stale_result", 64'(bad), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
